lenet_accelerator: RTL and testbench

Streaming two-stage convolutional feature extractor for a LeNet-5 style network. It accepts one single-channel featmap1_size×featmap1_size fixed-point image in raster order and runs conv3×3 → ReLU → maxpool2×2 → depthwise conv3×3 → ReLU → maxpool2×2 across PE_Num parallel channels. The PE_Num×featmap5_size² results are streamed out channel-major. Pixels are normally supplied by rom_data, a 1024×16 ROM with combinational read (spo = mem[a]; its clk is unused) addressed by an upstream counter.

---
 rtl/lenet_accelerator.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_lenet_accelerator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_accelerator.sv
// lenet_accelerator: streaming conv3x3/ReLU/maxpool2x2 twice over PE_Num channels, then a channel-major dump.

// 3x3 uniform-weight convolution with ReLU and saturation; one input lane or one lane per output.
module lenet_conv #(
  parameter int unsigned LANES  = 1,
  parameter int unsigned OUTS   = 8,
  parameter int unsigned SIDE   = 30,
  parameter bit          PER_CH = 1'b1,
  parameter int unsigned DW     = 16,
  parameter int unsigned QW     = 11,
  parameter int unsigned LAT    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  input  logic [LANES-1:0][DW-1:0] in_data,
  output logic                     out_vld,
  output logic [OUTS-1:0][DW-1:0]  out_data
);
  localparam int unsigned CW = $clog2(SIDE);
  localparam int unsigned SW = DW + 4;
  localparam int unsigned PW = SW + DW;
  localparam bit          BCAST = (LANES == 1);
  localparam logic signed [PW-1:0] SAT = PW'((1 << (DW - 1)) - 1);

  logic [CW-1:0]           col, row;
  logic signed [DW-1:0]    lb1 [LANES][SIDE];
  logic signed [DW-1:0]    lb2 [LANES][SIDE];
  logic signed [SW-1:0]    cs_c [LANES];
  logic signed [SW-1:0]    cs_d1 [LANES];
  logic signed [SW-1:0]    cs_d2 [LANES];
  logic signed [SW-1:0]    sum_q [LANES];
  logic                    sum_vld;
  logic signed [PW-1:0]    prod_c [OUTS];
  logic signed [PW-1:0]    shr_c [OUTS];
  logic [OUTS-1:0][DW-1:0] res_c;
  logic [OUTS-1:0][DW-1:0] pipe_d [LAT-1];
  logic [LAT-2:0]          pipe_v;

  // Weights are uniform, so the window sum is the sum of three column sums.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      cs_c[l] = SW'(lb2[l][col]) + SW'(lb1[l][col]) + SW'($signed(in_data[l]));
    end
  end

  // Line buffers, column-sum window and position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      sum_vld <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        cs_d1[l] <= '0;
        cs_d2[l] <= '0;
        sum_q[l] <= '0;
        for (int s = 0; s < SIDE; s++) begin
          lb1[l][s] <= '0;
          lb2[l][s] <= '0;
        end
      end
    end else begin
      sum_vld <= 1'b0;
      if (in_vld) begin
        if (col == CW'(SIDE - 1)) begin
          col <= '0;
          row <= (row == CW'(SIDE - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        for (int l = 0; l < LANES; l++) begin
          lb2[l][col] <= lb1[l][col];
          lb1[l][col] <= $signed(in_data[l]);
          cs_d1[l]    <= cs_c[l];
          cs_d2[l]    <= cs_d1[l];
          sum_q[l]    <= cs_c[l] + cs_d1[l] + cs_d2[l];
        end
        sum_vld <= (row >= CW'(2)) && (col >= CW'(2));
      end
    end
  end

  // Scale by the channel weight, drop the fraction, ReLU and saturate.
  always_comb begin
    for (int o = 0; o < OUTS; o++) begin
      prod_c[o] = PW'(sum_q[BCAST ? 0 : o]) * PW'((PER_CH ? o + 1 : 1) << (QW - 3));
      shr_c[o]  = prod_c[o] >>> QW;
      if (shr_c[o] < 0)        res_c[o] = '0;
      else if (shr_c[o] > SAT) res_c[o] = DW'(SAT);
      else                     res_c[o] = DW'(shr_c[o]);
    end
  end

  // Delay line completing the fixed PE latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int k = 0; k < LAT - 1; k++) pipe_d[k] <= '0;
    end else begin
      pipe_v[0] <= sum_vld;
      pipe_d[0] <= res_c;
      for (int k = 1; k < LAT - 1; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
  end

  assign out_vld  = pipe_v[LAT-2];
  assign out_data = pipe_d[LAT-2];
endmodule

// Non-overlapping 2x2 signed max pool over a SIDE x SIDE stream per lane.
module lenet_pool #(
  parameter int unsigned LANES = 8,
  parameter int unsigned SIDE  = 28,
  parameter int unsigned DW    = 16,
  parameter int unsigned LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  input  logic [LANES-1:0][DW-1:0] in_data,
  output logic                     out_vld,
  output logic [LANES-1:0][DW-1:0] out_data
);
  localparam int unsigned CW = $clog2(SIDE);
  localparam int unsigned HS = SIDE / 2;

  logic [CW-1:0]            col, row;
  logic signed [DW-1:0]     hold [LANES];
  logic signed [DW-1:0]     pbuf [LANES][HS];
  logic signed [DW-1:0]     hmax_c [LANES];
  logic [LANES-1:0][DW-1:0] wmax_c;
  logic [LANES-1:0][DW-1:0] pipe_d [LAT];
  logic [LAT-1:0]           pipe_v;

  // Horizontal pair max, then against the stored upper-row pair max.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      hmax_c[l] = ($signed(in_data[l]) > hold[l]) ? $signed(in_data[l]) : hold[l];
      wmax_c[l] = (hmax_c[l] > pbuf[l][col[CW-1:1]]) ? hmax_c[l] : pbuf[l][col[CW-1:1]];
    end
  end

  // Pair/row storage, position counters and output pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      pipe_v <= '0;
      for (int k = 0; k < LAT; k++) pipe_d[k] <= '0;
      for (int l = 0; l < LANES; l++) begin
        hold[l] <= '0;
        for (int s = 0; s < HS; s++) pbuf[l][s] <= '0;
      end
    end else begin
      if (in_vld) begin
        if (col == CW'(SIDE - 1)) begin
          col <= '0;
          row <= (row == CW'(SIDE - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        for (int l = 0; l < LANES; l++) begin
          if (!col[0])      hold[l] <= $signed(in_data[l]);
          else if (!row[0]) pbuf[l][col[CW-1:1]] <= hmax_c[l];
        end
      end
      pipe_v[0] <= in_vld & col[0] & row[0];
      pipe_d[0] <= wmax_c;
      for (int k = 1; k < LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
  end

  assign out_vld  = pipe_v[LAT-1];
  assign out_data = pipe_d[LAT-1];
endmodule

module lenet_accelerator #(
  parameter int unsigned dwidth             = 16,
  parameter int unsigned qwidth             = 11,
  parameter int unsigned featmap1_size      = 30,
  parameter int unsigned featmap2_size      = 28,
  parameter int unsigned featmap3_size      = 14,
  parameter int unsigned featmap4_size      = 12,
  parameter int unsigned featmap5_size      = 6,
  parameter int unsigned ConvPE_latency     = 5,
  parameter int unsigned Maxpooling_latency = 2,
  parameter int unsigned PE_Num             = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_st,
  input  logic [dwidth-1:0] din,
  output logic [dwidth-1:0] dout,
  output logic              dout_st
);
  localparam int unsigned NRES = featmap5_size * featmap5_size;
  localparam int unsigned IW   = $clog2(NRES);
  localparam int unsigned CHW  = $clog2(PE_Num);

  typedef enum logic {S_IDLE, S_DUMP} state_t;

  logic                           c1_vld, p1_vld, c2_vld, p2_vld;
  logic [PE_Num-1:0][dwidth-1:0]  c1_data, p1_data, c2_data, p2_data;
  logic [dwidth-1:0]              res_mem [2][PE_Num][NRES];
  logic [IW-1:0]                  wr_idx;
  logic                           wr_slot, wr_last_c;
  state_t                         state, state_n;
  logic [CHW-1:0]                 rd_ch, rd_ch_n;
  logic [IW-1:0]                  rd_idx, rd_idx_n;
  logic                           rd_slot, rd_slot_n;
  logic [dwidth-1:0]              dout_n;
  logic                           dout_st_n;

  lenet_conv #(.LANES(1), .OUTS(PE_Num), .SIDE(featmap1_size), .PER_CH(1'b1),
               .DW(dwidth), .QW(qwidth), .LAT(ConvPE_latency)) u_conv1 (
    .clk(clk), .rst_n(rst_n), .in_vld(din_st), .in_data(din),
    .out_vld(c1_vld), .out_data(c1_data));

  lenet_pool #(.LANES(PE_Num), .SIDE(featmap2_size), .DW(dwidth),
               .LAT(Maxpooling_latency)) u_pool1 (
    .clk(clk), .rst_n(rst_n), .in_vld(c1_vld), .in_data(c1_data),
    .out_vld(p1_vld), .out_data(p1_data));

  lenet_conv #(.LANES(PE_Num), .OUTS(PE_Num), .SIDE(featmap3_size), .PER_CH(1'b0),
               .DW(dwidth), .QW(qwidth), .LAT(ConvPE_latency)) u_conv2 (
    .clk(clk), .rst_n(rst_n), .in_vld(p1_vld), .in_data(p1_data),
    .out_vld(c2_vld), .out_data(c2_data));

  lenet_pool #(.LANES(PE_Num), .SIDE(featmap4_size), .DW(dwidth),
               .LAT(Maxpooling_latency)) u_pool2 (
    .clk(clk), .rst_n(rst_n), .in_vld(c2_vld), .in_data(c2_data),
    .out_vld(p2_vld), .out_data(p2_data));

  assign wr_last_c = p2_vld && (wr_idx == IW'(NRES - 1));

  // Result storage, double-buffered so a new frame never overwrites an active dump.
  always_ff @(posedge clk) begin
    if (p2_vld) begin
      for (int c = 0; c < PE_Num; c++) res_mem[wr_slot][c][wr_idx] <= p2_data[c];
    end
  end

  // Write index and slot toggle at each completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx  <= '0;
      wr_slot <= 1'b0;
    end else if (p2_vld) begin
      if (wr_last_c) begin
        wr_idx  <= '0;
        wr_slot <= ~wr_slot;
      end else begin
        wr_idx <= wr_idx + 1'b1;
      end
    end
  end

  // Dump state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rd_ch   <= '0;
      rd_idx  <= '0;
      rd_slot <= 1'b0;
      dout    <= '0;
      dout_st <= 1'b0;
    end else begin
      state   <= state_n;
      rd_ch   <= rd_ch_n;
      rd_idx  <= rd_idx_n;
      rd_slot <= rd_slot_n;
      dout    <= dout_n;
      dout_st <= dout_st_n;
    end
  end

  // Dump sequencing: channel-major, row-major within a channel.
  always_comb begin
    state_n   = state;
    rd_ch_n   = rd_ch;
    rd_idx_n  = rd_idx;
    rd_slot_n = rd_slot;
    dout_n    = dout;
    dout_st_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_last_c) begin
          state_n   = S_DUMP;
          rd_ch_n   = '0;
          rd_idx_n  = '0;
          rd_slot_n = wr_slot;
        end
      end
      S_DUMP: begin
        dout_n    = res_mem[rd_slot][rd_ch][rd_idx];
        dout_st_n = 1'b1;
        if (rd_idx == IW'(NRES - 1)) begin
          rd_idx_n = '0;
          if (rd_ch == CHW'(PE_Num - 1)) state_n = S_IDLE;
          else                           rd_ch_n = rd_ch + 1'b1;
        end else begin
          rd_idx_n = rd_idx + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_lenet_accelerator.sv
// Self-checking bench for lenet_accelerator: constant-frame table, reference-model frames, reset and gap cases.
module tb_lenet_accelerator;
  localparam int NPIX = 900;
  localparam int NOUT = 288;

  logic        clk;
  logic        rst_n;
  logic        din_st;
  logic [15:0] din;
  logic [15:0] dout;
  logic        dout_st;

  lenet_accelerator dut (
    .clk(clk), .rst_n(rst_n), .din_st(din_st), .din(din),
    .dout(dout), .dout_st(dout_st));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pix;
    int gaps;
    int step;
    int cst;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_pix_cyc = 0;
  int run_len = 0;
  int got_q[$];
  int runs_q[$];
  int start_q[$];
  int ref_q[$];
  int img[NPIX];
  int c1[8][28][28];
  int p1[8][14][14];
  int c2[8][12][12];
  vec_t vecs[5];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (dout_st) begin
      if (run_len == 0) start_q.push_back(cyc);
      got_q.push_back(int'($signed(dout)));
      run_len++;
    end else if (run_len != 0) begin
      runs_q.push_back(run_len);
      run_len = 0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic int relu_sat(input longint v);
    if (v < 0) return 0;
    if (v > 32767) return 32767;
    return int'(v);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Reference: plain-arithmetic evaluation of the whole network for the image in img[].
  task automatic model_frame();
    longint acc;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 28; r++)
        for (int q = 0; q < 28; q++) begin
          acc = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              acc += longint'(img[(r + i) * 30 + q + j]) * longint'((c + 1) * 256);
          c1[c][r][q] = relu_sat(acc >>> 11);
        end
      for (int r = 0; r < 14; r++)
        for (int q = 0; q < 14; q++)
          p1[c][r][q] = max4(c1[c][2*r][2*q], c1[c][2*r][2*q+1],
                             c1[c][2*r+1][2*q], c1[c][2*r+1][2*q+1]);
      for (int r = 0; r < 12; r++)
        for (int q = 0; q < 12; q++) begin
          acc = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              acc += longint'(p1[c][r + i][q + j]) * 64'sd256;
          c2[c][r][q] = relu_sat(acc >>> 11);
        end
    end
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 6; r++)
        for (int q = 0; q < 6; q++)
          ref_q.push_back(max4(c2[c][2*r][2*q], c2[c][2*r][2*q+1],
                               c2[c][2*r+1][2*q], c2[c][2*r+1][2*q+1]));
  endtask

  task automatic fill_rule(input int step, input int cst);
    for (int i = 0; i < NOUT; i++) ref_q.push_back(cst + step * (i / 36 + 1));
  endtask

  task automatic clear_obs();
    got_q.delete();
    runs_q.delete();
    start_q.delete();
    ref_q.delete();
  endtask

  // Drive the first n pixels of img[], with an optional number of random idle gaps.
  task automatic drive_pixels(input int n, input int gaps);
    bit gap_at[NPIX];
    int placed;
    int p;
    for (int k = 0; k < NPIX; k++) gap_at[k] = 1'b0;
    placed = 0;
    while (placed < gaps) begin
      p = int'($urandom_range(1, n - 1));
      if (!gap_at[p]) begin
        gap_at[p] = 1'b1;
        placed++;
      end
    end
    for (int k = 0; k < n; k++) begin
      if (gap_at[k]) begin
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk);
          din_st = 1'b0;
          din    = 16'($urandom);
        end
      end
      @(negedge clk);
      din_st = 1'b1;
      din    = 16'(img[k]);
    end
  endtask

  task automatic finish_input();
    @(negedge clk);
    din_st = 1'b0;
    din    = '0;
    last_pix_cyc = cyc;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic compare(input string tag, input int nframes);
    int lat;
    check({tag, " word_count"}, got_q.size(), ref_q.size());
    check({tag, " dump_runs"}, runs_q.size(), nframes);
    for (int f = 0; f < runs_q.size(); f++)
      check($sformatf("%s run_len[%0d]", tag, f), runs_q[f], NOUT);
    if (start_q.size() > 0) begin
      lat = start_q[start_q.size() - 1] - last_pix_cyc;
      n_tests++;
      if (lat < 1 || lat > 64) begin
        n_fail++;
        $display("FAIL %s dump_latency: got %0d cycles, expected 1..64", tag, lat);
      end
    end
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
      check($sformatf("%s word[%0d]", tag, i), got_q[i], ref_q[i]);
  endtask

  initial begin
    rst_n  = 1'b0;
    din_st = 1'b0;
    din    = '0;
    vecs[0] = '{2048, 0, 2592, 0};
    vecs[1] = '{0, 0, 0, 0};
    vecs[2] = '{-2048, 0, 0, 0};
    vecs[3] = '{32767, 0, 0, 32767};
    vecs[4] = '{2048, 50, 2592, 0};

    repeat (3) @(negedge clk);
    check("reset dout", int'(dout), 0);
    check("reset dout_st", int'(dout_st), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Constant frames with closed-form expectations.
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < NPIX; k++) img[k] = vecs[v].pix;
      clear_obs();
      fill_rule(vecs[v].step, vecs[v].cst);
      drive_pixels(NPIX, vecs[v].gaps);
      finish_input();
      wait_words(NOUT, 3000);
      compare($sformatf("const%0d", v), 1);
      repeat (20) @(negedge clk);
    end

    // Ramp frame (rom contents) against the model; dout must then hold the last word.
    for (int k = 0; k < NPIX; k++) img[k] = k;
    clear_obs();
    model_frame();
    drive_pixels(NPIX, 0);
    finish_input();
    wait_words(NOUT, 3000);
    compare("ramp", 1);
    repeat (30) @(negedge clk);
    check("ramp dout_hold", int'($signed(dout)), ref_q[ref_q.size() - 1]);

    // Reset after 400 pixels aborts that frame; next frame dumps once.
    for (int k = 0; k < NPIX; k++) img[k] = 2048;
    clear_obs();
    drive_pixels(400, 0);
    @(negedge clk);
    din_st = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    check("midreset dout", int'(dout), 0);
    check("midreset dout_st", int'(dout_st), 0);
    rst_n = 1'b1;
    fill_rule(2592, 0);
    drive_pixels(NPIX, 0);
    finish_input();
    wait_words(NOUT, 3000);
    compare("midreset", 1);

    // Two ones frames separated by a long idle period.
    clear_obs();
    fill_rule(2592, 0);
    fill_rule(2592, 0);
    drive_pixels(NPIX, 0);
    finish_input();
    wait_words(NOUT, 3000);
    repeat (4000) @(negedge clk);
    drive_pixels(NPIX, 0);
    finish_input();
    wait_words(2 * NOUT, 3000);
    compare("idle4000", 2);

    // Back-to-back ramp then random frame: second frame runs during the first dump.
    clear_obs();
    for (int k = 0; k < NPIX; k++) img[k] = k;
    model_frame();
    drive_pixels(NPIX, 0);
    for (int k = 0; k < NPIX; k++) img[k] = int'($urandom_range(0, 4000)) - 2000;
    model_frame();
    drive_pixels(NPIX, 0);
    finish_input();
    wait_words(2 * NOUT, 5000);
    compare("back2back", 2);

    // Full-range random frame with random gaps.
    clear_obs();
    for (int k = 0; k < NPIX; k++) img[k] = int'($signed(16'($urandom)));
    model_frame();
    drive_pixels(NPIX, 20);
    finish_input();
    wait_words(NOUT, 4000);
    compare("random", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
